mcycle_sequencer: RTL and testbench

- Generates the one-hot T-state step (i_Cycle_Step) and one-hot M-cycle count (i_Cycle_Count) consumed by every instruction microcode block in the control unit.
- Advances one T-state per enabled clock and rolls to the next M-cycle after the last T-state.
- Restarts the M-cycle count when the active microcode signals instruction end.
- Provides stall freezing, HALT entry/exit, and a sticky overrun flag for instructions that never signal completion.

---
 rtl/mcycle_sequencer.sv | 107 ++++++++++
 tb/tb_mcycle_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mcycle_sequencer.sv
// T-state / M-cycle sequencer for the microcoded control unit.
// Emits one-hot step and count strobes and handles stall, HALT and overrun.
module mcycle_sequencer #(
  parameter int STEPS      = 4,
  parameter int MAX_CYCLES = 8
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Enable,
  input  logic                  i_Stall,
  input  logic                  i_Instr_Done,
  input  logic                  i_Halt,
  input  logic                  i_Wake,
  output logic [STEPS-1:0]      o_Cycle_Step,
  output logic [MAX_CYCLES-1:0] o_Cycle_Count,
  output logic                  o_New_Instr,
  output logic                  o_Halted,
  output logic                  o_Overrun
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  localparam logic [STEPS-1:0]      STEP_FIRST  = STEPS'(1);
  localparam logic [MAX_CYCLES-1:0] COUNT_FIRST = MAX_CYCLES'(1);

  state_t                  state_reg, state_next;
  logic [STEPS-1:0]        step_reg, step_next;
  logic [MAX_CYCLES-1:0]   count_reg, count_next;
  logic                    new_instr_reg, new_instr_next;
  logic                    overrun_reg, overrun_next;
  logic                    freeze;

  assign freeze = i_Stall | ~i_Enable;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_reg     <= RUN;
      step_reg      <= STEP_FIRST;
      count_reg     <= COUNT_FIRST;
      new_instr_reg <= 1'b1;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      step_reg      <= step_next;
      count_reg     <= count_next;
      new_instr_reg <= new_instr_next;
      overrun_reg   <= overrun_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    step_next      = step_reg;
    count_next     = count_reg;
    new_instr_next = 1'b0;
    overrun_next   = overrun_reg;

    if (!freeze) begin
      unique case (state_reg)
        RUN: begin
          if (!step_reg[STEPS-1]) begin
            step_next = {step_reg[STEPS-2:0], step_reg[STEPS-1]};
          end else begin
            step_next = STEP_FIRST;
            if (i_Instr_Done) begin
              // A pending wake cancels HALT so the interrupt is not lost.
              if (i_Halt && !i_Wake) begin
                state_next = HALTED;
                step_next  = '0;
                count_next = '0;
              end else begin
                count_next     = COUNT_FIRST;
                new_instr_next = 1'b1;
              end
            end else if (count_reg[MAX_CYCLES-1]) begin
              // Runaway instruction: restart at a fetch and remember it.
              count_next     = COUNT_FIRST;
              overrun_next   = 1'b1;
              new_instr_next = 1'b1;
            end else begin
              count_next = count_reg << 1;
            end
          end
        end
        HALTED: begin
          if (i_Wake) begin
            state_next     = RUN;
            step_next      = STEP_FIRST;
            count_next     = COUNT_FIRST;
            new_instr_next = 1'b1;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  assign o_Cycle_Step  = step_reg;
  assign o_Cycle_Count = count_reg;
  assign o_New_Instr   = new_instr_reg;
  assign o_Halted      = (state_reg == HALTED);
  assign o_Overrun     = overrun_reg;

endmodule

// File: tb/tb_mcycle_sequencer.sv
// Bench for mcycle_sequencer: directed scenarios then random traffic,
// all compared against an index-based reference model.
module tb_mcycle_sequencer;

  localparam int STEPS      = 4;
  localparam int MAX_CYCLES = 8;

  logic                  i_Clk = 1'b0;
  logic                  i_Reset = 1'b1;
  logic                  i_Enable = 1'b1;
  logic                  i_Stall = 1'b0;
  logic                  i_Instr_Done = 1'b0;
  logic                  i_Halt = 1'b0;
  logic                  i_Wake = 1'b0;
  logic [STEPS-1:0]      o_Cycle_Step;
  logic [MAX_CYCLES-1:0] o_Cycle_Count;
  logic                  o_New_Instr;
  logic                  o_Halted;
  logic                  o_Overrun;

  int vec_count = 0;
  int err_count = 0;

  // Reference model: T-state index, M-cycle index and flags.
  int m_step = 0;
  int m_cyc  = 0;
  bit m_halted = 0;
  bit m_ovr = 0;
  bit m_new = 0;
  int since_new = 0;

  mcycle_sequencer #(.STEPS(STEPS), .MAX_CYCLES(MAX_CYCLES)) dut (
    .i_Clk        (i_Clk),
    .i_Reset      (i_Reset),
    .i_Enable     (i_Enable),
    .i_Stall      (i_Stall),
    .i_Instr_Done (i_Instr_Done),
    .i_Halt       (i_Halt),
    .i_Wake       (i_Wake),
    .o_Cycle_Step (o_Cycle_Step),
    .o_Cycle_Count(o_Cycle_Count),
    .o_New_Instr  (o_New_Instr),
    .o_Halted     (o_Halted),
    .o_Overrun    (o_Overrun)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      err_count++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic model_update(input bit rst, en, stall, done, halt, wake);
    if (rst) begin
      m_step = 0; m_cyc = 0; m_halted = 0; m_ovr = 0; m_new = 1;
    end else if (stall || !en) begin
      m_new = 0;
    end else if (m_halted) begin
      if (wake) begin
        m_halted = 0; m_step = 0; m_cyc = 0; m_new = 1;
      end else begin
        m_new = 0;
      end
    end else if (m_step < STEPS - 1) begin
      m_step++; m_new = 0;
    end else begin
      m_step = 0;
      if (done && halt && !wake) begin
        m_halted = 1; m_new = 0;
      end else if (done) begin
        m_cyc = 0; m_new = 1;
      end else if (m_cyc == MAX_CYCLES - 1) begin
        m_cyc = 0; m_ovr = 1; m_new = 1;
      end else begin
        m_cyc++; m_new = 0;
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_step, exp_cnt;
    exp_step = m_halted ? 32'd0 : (32'd1 << m_step);
    exp_cnt  = m_halted ? 32'd0 : (32'd1 << m_cyc);
    check("step",    32'(o_Cycle_Step),  exp_step);
    check("count",   32'(o_Cycle_Count), exp_cnt);
    check("new",     32'(o_New_Instr),   32'(m_new));
    check("halted",  32'(o_Halted),      32'(m_halted));
    check("overrun", 32'(o_Overrun),     32'(m_ovr));
  endtask

  task automatic apply(input bit rst, en, stall, done, halt, wake);
    i_Reset = rst; i_Enable = en; i_Stall = stall;
    i_Instr_Done = done; i_Halt = halt; i_Wake = wake;
    @(posedge i_Clk);
    model_update(rst, en, stall, done, halt, wake);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    // Basic stepping and a two-M-cycle instruction measured between pulses.
    apply(1, 1, 0, 0, 0, 0);
    since_new = 0;
    for (int k = 1; k <= 8; k++) begin
      apply(0, 1, 0, (k == 8), 0, 0);
      since_new++;
      if (o_New_Instr) break;
    end
    check("span_clocks", 32'(since_new), 32'd8);

    // Stall for three clocks while at step 0100.
    apply(1, 1, 0, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 3; i++) apply(0, 1, 1, 0, 0, 1);
    apply(0, 0, 0, 1, 0, 0);
    idle(3);

    // HALT entry, wake after 10 clocks, then HALT cancelled by wake.
    apply(1, 1, 0, 0, 0, 0);
    idle(3);
    apply(0, 1, 0, 1, 1, 0);
    for (int i = 0; i < 10; i++) apply(0, 1, 0, 1, 1, 0);
    apply(0, 1, 1, 0, 0, 1);
    apply(0, 1, 0, 0, 0, 1);
    idle(3);
    apply(0, 1, 0, 1, 1, 1);
    check("halt_skipped", 32'(o_Halted), 32'd0);

    // Overrun after 32+ clocks without done, then reset from HALTED and mid-M-cycle 3.
    apply(1, 1, 0, 0, 0, 0);
    idle(40);
    check("overrun_sticky", 32'(o_Overrun), 32'd1);
    idle(3);
    apply(0, 1, 0, 1, 1, 0);
    apply(1, 1, 0, 0, 0, 0);
    idle(10);
    apply(1, 1, 0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, en, st, dn, hl, wk;
      r  = ($urandom_range(0, 299) == 0);
      en = ($urandom_range(0, 15) != 0);
      st = ($urandom_range(0, 7) == 0);
      dn = ($urandom_range(0, 3) == 0);
      hl = ($urandom_range(0, 2) == 0);
      wk = ($urandom_range(0, 7) == 0);
      apply(r, en, st, dn, hl, wk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
